clk_gate_ctrl: RTL

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_pkg.sv | 19 +
 rtl/clk_gate_ch.sv | 117 +++++++++++
 rtl/clk_gate_ctrl.sv | 42 ++++
 3 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and default sizing for the clock-gate controller.
// Each channel runs the same OFF/WAKE/ON/DRAIN state machine.
package clk_gate_pkg;

    localparam int NB_CH_DEF    = 4;
    localparam int IDLE_W_DEF   = 8;
    localparam int WAKE_CYC_DEF = 2;

    // Wide enough for the largest legal WAKE_CYC (15).
    localparam int WAKE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } ch_state_e;

endpackage : clk_gate_pkg

// File: rtl/clk_gate_ch.sv
// One gated-clock channel: state machine, idle and wake counters, and the
// falling-edge enable flop that feeds an AND-type clock gate.
module clk_gate_ch
    import clk_gate_pkg::*;
#(
    parameter int IDLE_W   = IDLE_W_DEF,
    parameter int WAKE_CYC = WAKE_CYC_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sw_en,
    input  logic              i_auto_en,
    input  logic              i_wake_req,
    input  logic              i_busy,
    input  logic [IDLE_W-1:0] i_idle_thr,
    input  logic              i_stop_ack,
    output logic              o_en,
    output logic              o_stop_req,
    output logic              o_active
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYC - 1);

    ch_state_e               state;
    logic [WAKE_CNT_W-1:0]   wake_cnt;
    logic [IDLE_W-1:0]       idle_cnt;

    logic thr_zero;
    logic auto_active;
    logic idle_hit;
    logic idle_clr;
    logic en_int;

    // A zero threshold switches auto-gating off for every channel.
    assign thr_zero    = (i_idle_thr == '0);
    assign auto_active = i_auto_en && !thr_zero;
    assign idle_hit    = auto_active && (idle_cnt >= i_idle_thr);
    assign idle_clr    = i_busy || i_wake_req || !auto_active;
    assign en_int      = (state != ST_OFF);

    // NOTE: every register below is assigned with <= so all flops update
    // together from pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_OFF;
            wake_cnt   <= '0;
            idle_cnt   <= '0;
            o_stop_req <= 1'b0;
            o_active   <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (i_sw_en && (!i_auto_en || i_wake_req || thr_zero)) begin
                        state    <= ST_WAKE;
                        wake_cnt <= '0;
                    end
                end

                ST_WAKE: begin
                    if (!i_sw_en) begin
                        state <= ST_OFF;
                    end else if (wake_cnt == WAKE_LAST) begin
                        state    <= ST_ON;
                        idle_cnt <= '0;
                        o_active <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end

                ST_ON: begin
                    // Software disable and idle timeout share the same target.
                    if (!i_sw_en || idle_hit) begin
                        state      <= ST_DRAIN;
                        o_active   <= 1'b0;
                        o_stop_req <= 1'b1;
                    end
                    if (idle_clr) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    // The acknowledge wins over a concurrent abort request.
                    if (i_stop_ack) begin
                        state      <= ST_OFF;
                        o_stop_req <= 1'b0;
                    end else if (i_sw_en && i_wake_req) begin
                        state      <= ST_ON;
                        idle_cnt   <= '0;
                        o_stop_req <= 1'b0;
                        o_active   <= 1'b1;
                    end
                end

                default: begin
                    state      <= ST_OFF;
                    o_stop_req <= 1'b0;
                    o_active   <= 1'b0;
                end
            endcase
        end
    end

    // Updating on the falling edge keeps the gate enable stable while the
    // clock is high, so the AND gate never produces a runt pulse.
    always_ff @(negedge i_clk) begin
        if (!i_rst_n) begin
            o_en <= 1'b0;
        end else begin
            o_en <= en_int;
        end
    end

endmodule : clk_gate_ch

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: NB_CH independent channels sharing one clock,
// one reset and a common idle threshold.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NB_CH    = NB_CH_DEF,
    parameter int IDLE_W   = IDLE_W_DEF,
    parameter int WAKE_CYC = WAKE_CYC_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NB_CH-1:0]  i_sw_en,
    input  logic [NB_CH-1:0]  i_auto_en,
    input  logic [NB_CH-1:0]  i_wake_req,
    input  logic [NB_CH-1:0]  i_busy,
    input  logic [IDLE_W-1:0] i_idle_thr,
    input  logic [NB_CH-1:0]  i_stop_ack,
    output logic [NB_CH-1:0]  o_en,
    output logic [NB_CH-1:0]  o_stop_req,
    output logic [NB_CH-1:0]  o_active
);

    for (genvar g = 0; g < NB_CH; g++) begin : g_ch
        clk_gate_ch #(
            .IDLE_W   (IDLE_W),
            .WAKE_CYC (WAKE_CYC)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_sw_en    (i_sw_en[g]),
            .i_auto_en  (i_auto_en[g]),
            .i_wake_req (i_wake_req[g]),
            .i_busy     (i_busy[g]),
            .i_idle_thr (i_idle_thr),
            .i_stop_ack (i_stop_ack[g]),
            .o_en       (o_en[g]),
            .o_stop_req (o_stop_req[g]),
            .o_active   (o_active[g])
        );
    end

endmodule : clk_gate_ctrl
